// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between NUM_REQ requesters.
// Responses are routed back to the issuing requester through an in-flight tag pipeline.
module bram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PIPELINED  = 0
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             bram_en,
  output logic                             bram_we,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_din,
  input  logic [DATA_WIDTH-1:0]            bram_dout
);

  localparam int LAT = 1 + PIPELINED;
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0] W_NUM = (IDW+1)'(NUM_REQ);

  logic [IDW-1:0] r_ptr;
  logic [LAT-1:0] r_tag_v;
  logic [IDW-1:0] r_tag_id [LAT];

  logic           w_any;
  logic [IDW-1:0] w_gid;
  logic [IDW-1:0] w_idx;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_ptr_nxt;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_any     = 1'b0;
    w_gid     = '0;
    w_idx     = '0;
    w_sum     = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= W_NUM) w_sum = w_sum - W_NUM;
      w_idx = w_sum[IDW-1:0];
      if (!RST && !w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gid = w_idx;
      end
    end
    if (w_any) req_ready[w_gid] = 1'b1;
  end

  always_comb begin
    bram_en   = w_any;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (w_any) begin
      bram_we   = req_we[w_gid];
      bram_addr = req_addr[int'(w_gid)*ADDR_WIDTH +: ADDR_WIDTH];
      bram_din  = req_wdata[int'(w_gid)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_ptr_nxt = (w_gid == IDW'(NUM_REQ-1)) ? '0 : w_gid + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr   <= '0;
      r_tag_v <= '0;
      for (int i = 0; i < LAT; i++) r_tag_id[i] <= '0;
    end else begin
      if (w_any) r_ptr <= w_ptr_nxt;
      r_tag_v[0]  <= w_any;
      r_tag_id[0] <= w_gid;
      for (int i = 1; i < LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  // Gated by RST so a tag still in flight when reset arrives never surfaces.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (!RST && r_tag_v[LAT-1]) begin
      rsp_valid[r_tag_id[LAT-1]] = 1'b1;
      rsp_data                   = bram_dout;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: one instance per read latency, each behind a write-first RAM model,
// checked every cycle against a queue-based reference of grants and due responses.
module tb_bram_port_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RST;
  logic [NR-1:0]    req_valid, req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;

  logic [NR-1:0] rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rd0, rd1, din0, din1, dout0, dout1, q1a;
  logic [AW-1:0] addr0, addr1;
  logic          en0, en1, we0, we1;

  logic [DW-1:0] ram0 [256];
  logic [DW-1:0] ram1 [256];

  always #5 CLK = ~CLK;

  bram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(0)) dut0 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv0), .rsp_data(rd0),
    .bram_en(en0), .bram_we(we0), .bram_addr(addr0), .bram_din(din0), .bram_dout(dout0));

  bram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(1)) dut1 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_data(rd1),
    .bram_en(en1), .bram_we(we1), .bram_addr(addr1), .bram_din(din1), .bram_dout(dout1));

  // Write-first RAMs: 1-cycle for dut0, extra output register for dut1.
  always @(posedge CLK) begin
    if (en0) begin
      if (we0) begin
        ram0[addr0] <= din0;
        dout0       <= din0;
      end else dout0 <= ram0[addr0];
    end
  end

  always @(posedge CLK) begin
    if (en1) begin
      if (we1) begin
        ram1[addr1] <= din1;
        q1a         <= din1;
      end else q1a <= ram1[addr1];
    end
    dout1 <= q1a;
  end

  // Reference model state
  typedef struct {int due; int id; logic [DW-1:0] data;} rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] pre_val [256];
  int m_ptr, cyc, exp_g;
  int n_total, n_bad;
  logic [NR-1:0] e_ready, e_v0, e_v1;
  logic [DW-1:0] e_d0, e_d1, e_din;
  logic          e_en, e_we;
  logic [AW-1:0] e_addr;

  function automatic logic [121:0] observed();
    return {rdy0, rdy1, en0, we0, addr0, din0, rv0, rd0, rv1, rd1};
  endfunction

  function automatic logic [121:0] expected();
    return {e_ready, e_ready, e_en, e_we, e_addr, e_din, e_v0, e_d0, e_v1, e_d1};
  endfunction

  task automatic model_eval();
    e_ready = '0; exp_g = -1;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
    if (!RST)
      for (int k = 0; k < NR; k++)
        if (exp_g < 0 && req_valid[(m_ptr + k) % NR]) exp_g = (m_ptr + k) % NR;
    if (exp_g >= 0) begin
      e_ready[exp_g] = 1'b1;
      e_en   = 1'b1;
      e_we   = req_we[exp_g];
      e_addr = req_addr[exp_g*AW +: AW];
      e_din  = req_wdata[exp_g*DW +: DW];
    end
    e_v0 = '0; e_d0 = '0; e_v1 = '0; e_d1 = '0;
    if (!RST && q0.size() > 0 && q0[0].due == cyc) begin
      e_v0[q0[0].id] = 1'b1; e_d0 = q0[0].data;
    end
    if (!RST && q1.size() > 0 && q1[0].due == cyc) begin
      e_v1[q1[0].id] = 1'b1; e_d1 = q1[0].data;
    end
  endtask

  task automatic model_commit();
    logic [DW-1:0] d;
    while (q0.size() > 0 && q0[0].due <= cyc) void'(q0.pop_front());
    while (q1.size() > 0 && q1[0].due <= cyc) void'(q1.pop_front());
    cyc++;
    if (RST) begin
      q0.delete(); q1.delete(); m_ptr = 0;
    end else if (exp_g >= 0) begin
      d = e_we ? e_din : shadow[e_addr];
      if (e_we) shadow[e_addr] = e_din;
      q0.push_back('{cyc, exp_g, d});
      q1.push_back('{cyc + 1, exp_g, d});
      m_ptr = (exp_g + 1) % NR;
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    model_commit();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin RST = 1'b0; clear_reqs(); end
      else for (int i = 0; i < NR; i++) set_req(i, 1'($urandom_range(0, 1)), 1'b0, 8'(i), 32'(i));
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL reset_model c=%0d got=%h want=%h", c, observed(), expected());
      end
      n_total++;
      if ({rdy0, rv0, rv1, en0, we0, addr0, din0, rd0} !== '0) begin
        n_bad++; $display("FAIL reset_zero c=%0d rdy=%b rv=%b en=%b addr=%h din=%h", c, rdy0, rv0, en0, addr0, din0);
      end
      advance();
    end
  endtask

  task automatic test_preload();
    for (int a = 0; a < 256; a++) begin
      pre_val[a] = (a == 3) ? 32'h1234 : (a == 4) ? 32'h5678 : $urandom();
      clear_reqs();
      set_req(0, 1'b1, 1'b1, 8'(a), pre_val[a]);
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL preload a=%0d got=%h want=%h", a, observed(), expected());
      end
      advance();
    end
  endtask

  task automatic test_write_read();
    for (int c = 0; c < 4; c++) begin
      clear_reqs();
      if (c == 0) set_req(2, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
      if (c == 1) set_req(2, 1'b1, 1'b0, 8'h10, 32'h0);
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL write_read c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (c == 0) begin
        n_total++;
        if ({en0, we0, rdy0, addr0} !== {1'b1, 1'b1, 4'b0100, 8'h10}) begin
          n_bad++; $display("FAIL wr_issue en=%b we=%b rdy=%b addr=%h want 1 1 0100 10", en0, we0, rdy0, addr0);
        end
      end
      if (c == 1 || c == 2) begin
        n_total++;
        if ({rv0, rd0} !== {4'b0100, 32'hDEADBEEF}) begin
          n_bad++; $display("FAIL wr_rd_rsp c=%0d rv=%b data=%h want 0100 deadbeef", c, rv0, rd0);
        end
      end
      advance();
    end
  endtask

  task automatic test_rotation();
    RST = 1'b1; clear_reqs();
    @(negedge CLK); model_eval(); advance();
    RST = 1'b0;
    for (int c = 0; c < 10; c++) begin
      clear_reqs();
      if (c < 8) for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 8'(8'h20 + i), 32'h0);
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL rotation c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (c < 8) begin
        n_total++;
        if (rdy0 !== 4'(1 << (c % 4))) begin
          n_bad++; $display("FAIL rot_ready c=%0d got=%b want=%b", c, rdy0, 4'(1 << (c % 4)));
        end
      end
      if (c >= 1 && c <= 8) begin
        n_total++;
        if ({rv0, rd0} !== {4'(1 << ((c - 1) % 4)), pre_val[8'h20 + (c - 1) % 4]}) begin
          n_bad++; $display("FAIL rot_rsp c=%0d rv=%b data=%h want %b %h", c, rv0, rd0,
                            4'(1 << ((c - 1) % 4)), pre_val[8'h20 + (c - 1) % 4]);
        end
      end
      advance();
    end
  endtask

  task automatic test_pipelined_b2b();
    for (int c = 0; c < 5; c++) begin
      clear_reqs();
      if (c == 0) set_req(0, 1'b1, 1'b0, 8'd3, 32'h0);
      if (c == 1) set_req(1, 1'b1, 1'b0, 8'd4, 32'h0);
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL pipelined c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (c == 2 || c == 3) begin
        n_total++;
        if ({rv1, rd1} !== ((c == 2) ? {4'b0001, 32'h1234} : {4'b0010, 32'h5678})) begin
          n_bad++; $display("FAIL pipe_rsp c=%0d rv=%b data=%h", c, rv1, rd1);
        end
      end
      advance();
    end
  endtask

  task automatic test_raw();
    for (int c = 0; c < 4; c++) begin
      clear_reqs();
      if (c == 0) set_req(1, 1'b1, 1'b1, 8'd7, 32'hA5A5A5A5);
      if (c == 1) set_req(3, 1'b1, 1'b0, 8'd7, 32'h0);
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL raw c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (c == 2) begin
        n_total++;
        if ({rv0, rd0} !== {4'b1000, 32'hA5A5A5A5}) begin
          n_bad++; $display("FAIL raw_rsp rv=%b data=%h want 1000 a5a5a5a5", rv0, rd0);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 8; c++) begin
      clear_reqs();
      RST = (c == 2);
      if (c == 0) set_req(1, 1'b1, 1'b0, 8'd5, 32'h0);
      if (c == 1) set_req(0, 1'b1, 1'b0, 8'd6, 32'h0);
      if (c == 5) begin set_req(0, 1'b1, 1'b0, 8'd8, 32'h0); set_req(1, 1'b1, 1'b0, 8'd9, 32'h0); end
      if (c == 6) set_req(1, 1'b1, 1'b0, 8'd9, 32'h0);
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL reset_mid c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (c >= 2 && c <= 5) begin
        n_total++;
        if ({rv0, rv1} !== 8'h00) begin
          n_bad++; $display("FAIL rst_drop c=%0d rv0=%b rv1=%b want 0", c, rv0, rv1);
        end
      end
      if (c == 5) begin
        n_total++;
        if (rdy0 !== 4'b0001) begin
          n_bad++; $display("FAIL rst_ptr got=%b want=0001", rdy0);
        end
      end
      advance();
    end
    RST = 1'b0;
  endtask

  task automatic test_single();
    for (int c = 0; c < 7; c++) begin
      clear_reqs();
      if (c < 5) set_req(3, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL single c=%0d got=%h want=%h", c, observed(), expected());
      end
      if (c < 5) begin
        n_total++;
        if (rdy0 !== 4'b1000) begin
          n_bad++; $display("FAIL single_ready c=%0d got=%b want=1000", c, rdy0);
        end
      end
      if (c >= 1 && c <= 5) begin
        n_total++;
        if (rv0 !== 4'b1000) begin
          n_bad++; $display("FAIL single_rsp c=%0d got=%b want=1000", c, rv0);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    clear_reqs();
    RST = 1'b0;
    for (int c = 0; c < 400; c++) begin
      // Pending requests are held until granted; free slots get fresh random traffic.
      for (int i = 0; i < NR; i++)
        if (!req_valid[i])
          set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 15)), $urandom());
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL random c=%0d got=%h want=%h", c, observed(), expected());
      end
      advance();
      if (exp_g >= 0) req_valid[exp_g] = 1'b0;
      RST = ($urandom_range(0, 39) == 0);
    end
    RST = 1'b0;
    clear_reqs();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); model_eval();
      n_total++;
      if (observed() !== expected()) begin
        n_bad++; $display("FAIL random_drain c=%0d got=%h want=%h", c, observed(), expected());
      end
      advance();
    end
  endtask

  initial begin
    n_total = 0; n_bad = 0; m_ptr = 0; cyc = 0;
    RST = 1'b1;
    clear_reqs();
    test_reset();
    test_preload();
    test_write_read();
    test_rotation();
    test_pipelined_b2b();
    test_raw();
    test_reset_mid();
    test_single();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
